seg_display_arbiter: RTL
========================

# seg_display_arbiter

APB-controlled owner arbiter and scan sequencer for the shared 6-digit seven-segment display on the Cortex-M3 SoC peripheral bus. The display has two requesters:
- a hardware BCD source, e.g. the stopwatch timer, using a req/gnt handshake;
- software, through a memory-mapped data register.

The block picks the owner at frame boundaries, captures the owner's digits into a shadow buffer so frames never tear, and drives the multiplexed `seg`/`dig` pins.

## Interface
- `CLK_DIV`, 25000: PCLK cycles per digit scan step.
- `HOLD_FRAMES`, 64: frames an owner keeps the display in round-robin mode while the other requester waits.

- `PCLK`  in  1  clock.
- `PRESETn`  in  1  reset, asynchronous, active-low.
- `PSEL`, `PENABLE`, `PWRITE`  in  1 each  APB control.
- `PADDR`  in  [11:2]  word address; only [4:2] is decoded.
- `PWDATA`  in  32  write data.
- `PRDATA`  out  32  read data, combinational from PADDR.
- `PREADY`  out  1  constant 1.
- `PSLVERR`  out  1  constant 0.
- `hw_req`  in  1  hardware source wants the display; level, held while requesting.
- `hw_bcd`  in  24  hardware digits; nibble k is digit k, digit 0 rightmost.
- `hw_gnt`  out  1  hardware source owns the display.
- `seg`  out  8  segment pattern, active-high, bit 7 = dp (always 0).
- `dig`  out  6  digit select, active-low one-hot.

## Operation
- APB write strobe: PSEL & ~PENABLE & PWRITE (setup phase). Reads have zero wait states.
- Registers:
  - 0x00 CTRL: [0] EN; [2:1] MODE. Reset 0.
  - 0x04 SWDATA: [23:0] BCD digits. Reset 0.
  - 0x08 STATUS (read-only): [0] owner (1 = HW); [1] hw_gnt; [4:2] scan index; [6:5] state.
  - 0x0C DIGMASK: [5:0] digit lit mask. Reset 0x3F.
  - Other offsets read 0; writes to them are ignored.
- Prescaler runs 0..CLK_DIV-1 while EN=1; `tick` = prescaler at CLK_DIV-1.
- Scan index advances 0..5 on each tick and wraps to 0. `frame_end` = tick with index 5.
- Owner FSM states: IDLE=0, SW=1, HW=2. The target state depends on MODE:
  - 00: SW.
  - 01: HW if hw_req, else IDLE.
  - 10: HW if hw_req, else SW.
  - 11: round-robin. With hw_req=0 the target is SW. With hw_req=1, ownership alternates SW↔HW every HOLD_FRAMES frames, using a frame counter that clears on every owner change.
- Transitions:
  - EN=0 forces IDLE on the next edge from any state. The prescaler, scan index and frame counter clear.
  - From IDLE, the FSM moves to the target on the first edge where the target is not IDLE. No frame alignment is applied.
  - Between SW, HW and IDLE, while EN=1: only at frame_end.
- Shadow buffer (24 bit) loads from the new owner's source on every IDLE exit and at every frame_end: SWDATA in SW, hw_bcd in HW.
- `hw_gnt` = (state == HW), registered.
- Display output:
  - State ≠ IDLE and DIGMASK[idx]=1: dig = ~(1<<idx), seg = glyph(shadow nibble idx).
  - Otherwise: dig = 0x3F, seg = 0x00.
- BCD glyphs 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Nibbles A–F: see Configuration.

## Timing
- Reset values: seg=0x00, dig=0x3F, hw_gnt=0, state IDLE, index 0, prescaler 0, shadow 0.
- Register writes are visible at the next PCLK edge.
- MODE changes and hw_req changes take effect at the next frame_end. The IDLE exit and EN=0 rules are the exceptions.
- SWDATA write in the same cycle as a shadow load: the shadow takes the old SWDATA. The new value shows from the next frame.
- hw_req dropped while in HW: ownership is held until frame_end, and hw_gnt falls on the edge after it.
- seg/dig/hw_gnt are registered outputs, one cycle behind the state/index that produces them.

## Configuration
- `SEG_HEX_EN` defined: nibbles A–F decode to 77 7C 39 5E 79 71.
- `SEG_HEX_EN` undefined: nibbles A–F decode to 0x00 (blank).

## Structure
- Package `seg_disp_pkg`: FSM state enum, register offsets, NUM_DIGITS=6, glyph constants.
- Sub-module `seg7_decoder`: combinational nibble→glyph decoder; contains the `SEG_HEX_EN` switch.

## Test plan
Bench uses CLK_DIV=4, HOLD_FRAMES=2.
- Reset: release PRESETn → seg=0x00, dig=0x3F, hw_gnt=0; DIGMASK reads 0x3F; CTRL reads 0.
- SW display: SWDATA=0x123456, CTRL=0x1 → IDLE exit, then dig=0x3E with seg=0x7D; 4 cycles later dig=0x3D with seg=0x6D; after 24 cycles back to dig=0x3E.
- HW priority: MODE=10 with SW showing; raise hw_req mid-frame with hw_bcd=0x000009 → hw_gnt rises the edge after frame_end; digit 0 seg=0x6F. Drop hw_req → SW is restored after the following frame_end.
- Round-robin: MODE=11, hw_req held → owner toggles every 48 cycles; STATUS[0] alternates and hw_gnt matches it.
- Hex glyphs: SWDATA=0x00000A → digit 0 seg=0x00 without `SEG_HEX_EN`, seg=0x77 with it.
- Mask and disable: DIGMASK=0x01 → only dig=0x3E is ever driven; the other 5 slots show dig=0x3F, seg=0x00. Clear EN mid-frame → next cycle dig=0x3F, seg=0x00, STATUS index 0.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// Contents: owner FSM state enum, APB register word offsets, CTRL.MODE encodings,
// digit count and segment glyph constants (active-high, bit 7 = dp, always 0).
package seg_disp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSw   = 2'd1,
    StHw   = 2'd2
  } owner_state_e;

  localparam int unsigned NUM_DIGITS = 6;

  // Word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;  // 0x00
  localparam logic [2:0] REG_SWDATA  = 3'd1;  // 0x04
  localparam logic [2:0] REG_STATUS  = 3'd2;  // 0x08
  localparam logic [2:0] REG_DIGMASK = 3'd3;  // 0x0C

  localparam logic [1:0] MODE_SW      = 2'b00;
  localparam logic [1:0] MODE_HW_ONLY = 2'b01;
  localparam logic [1:0] MODE_HW_PRIO = 2'b10;
  localparam logic [1:0] MODE_RR      = 2'b11;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_0 = 8'h3F;
  localparam logic [7:0] GLYPH_1 = 8'h06;
  localparam logic [7:0] GLYPH_2 = 8'h5B;
  localparam logic [7:0] GLYPH_3 = 8'h4F;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'h6D;
  localparam logic [7:0] GLYPH_6 = 8'h7D;
  localparam logic [7:0] GLYPH_7 = 8'h07;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h6F;
  localparam logic [7:0] GLYPH_A = 8'h77;
  localparam logic [7:0] GLYPH_B = 8'h7C;
  localparam logic [7:0] GLYPH_C = 8'h39;
  localparam logic [7:0] GLYPH_D = 8'h5E;
  localparam logic [7:0] GLYPH_E = 8'h79;
  localparam logic [7:0] GLYPH_F = 8'h71;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Bus bundle for seg_display_arbiter: APB slave signals plus the hardware BCD
// source req/gnt handshake.
//   master : APB requester / hardware source side (drives PSEL..PWDATA, hw_req, hw_bcd)
//   slave  : arbiter side (drives PRDATA, PREADY, PSLVERR, hw_gnt)
interface seg_display_arbiter_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  logic        hw_req;
  logic [23:0] hw_bcd;
  logic        hw_gnt;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, hw_req, hw_bcd,
    input  PRDATA, PREADY, PSLVERR, hw_gnt
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, hw_req, hw_bcd,
    output PRDATA, PREADY, PSLVERR, hw_gnt
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD/hex nibble to seven-segment glyph decoder.
// Ports: nibble (4-bit digit value in), glyph (8-bit active-high segments out, dp = 0).
// Build option SEG_HEX_EN: when defined, nibbles A-F show hex letters; otherwise they blank.
module seg7_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
`ifdef SEG_HEX_EN
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
`else
      // Non-BCD nibbles blank the digit
`endif
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Owner arbiter and scan sequencer for a shared 6-digit seven-segment display.
// Picks the owner (software SWDATA register or hardware BCD source) at frame
// boundaries, latches that owner's digits into a shadow buffer so a frame never
// tears, and scans the multiplexed seg/dig pins.
// Ports:
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   bus (slave)   : APB registers (CTRL, SWDATA, STATUS, DIGMASK) and hw_req/hw_bcd/hw_gnt
//   seg           : segment pattern, active-high, bit 7 = dp (always 0), registered
//   dig           : digit select, active-low one-hot, registered
// Build option SEG_HEX_EN (inside seg7_decoder): hex glyphs for nibbles A-F.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 25000,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  seg_display_arbiter_if.slave  bus,
  output logic [7:0]            seg,
  output logic [5:0]            dig
);

  localparam int unsigned PresW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FrmW  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_DIV - 1);
  localparam logic [FrmW-1:0]  HoldMax = FrmW'(HOLD_FRAMES - 1);
  localparam logic [2:0]       IdxMax  = 3'(NUM_DIGITS - 1);

  // Register file
  logic        en_q;
  logic [1:0]  mode_q;
  logic [23:0] swdata_q;
  logic [5:0]  digmask_q;
  logic        apb_wr;
  logic [2:0]  reg_sel;

  assign apb_wr  = bus.PSEL & ~bus.PENABLE & bus.PWRITE;
  assign reg_sel = bus.PADDR[4:2];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_SW;
      swdata_q  <= '0;
      digmask_q <= 6'h3F;
    end else if (apb_wr) begin
      case (reg_sel)
        REG_CTRL: begin
          en_q   <= bus.PWDATA[0];
          mode_q <= bus.PWDATA[2:1];
        end
        REG_SWDATA:  swdata_q  <= bus.PWDATA[23:0];
        REG_DIGMASK: digmask_q <= bus.PWDATA[5:0];
        default: ;
      endcase
    end
  end

  // Scan timing
  logic [PresW-1:0] pres_q;
  logic [2:0]       idx_q;
  logic             tick;
  logic             frame_end;

  assign tick      = en_q && (pres_q == PresMax);
  assign frame_end = tick && (idx_q == IdxMax);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pres_q <= '0;
      idx_q  <= '0;
    end else if (!en_q) begin
      pres_q <= '0;
      idx_q  <= '0;
    end else begin
      pres_q <= tick ? '0 : pres_q + 1'b1;
      if (tick) begin
        idx_q <= (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

  // Owner FSM
  owner_state_e     state_q, state_d, target;
  logic [FrmW-1:0]  frm_q;
  logic             hold_done;
  logic [23:0]      shadow_q;
  logic             shadow_load;

  // Counter saturates, so a long uncontested SW tenure lets HW in at the next frame_end
  assign hold_done = (frm_q == HoldMax);

  always_comb begin
    target = StSw;
    case (mode_q)
      MODE_SW:      target = StSw;
      MODE_HW_ONLY: target = bus.hw_req ? StHw : StIdle;
      MODE_HW_PRIO: target = bus.hw_req ? StHw : StSw;
      MODE_RR: begin
        if (!bus.hw_req) begin
          target = StSw;
        end else begin
          case (state_q)
            StSw:    target = hold_done ? StHw : StSw;
            StHw:    target = hold_done ? StSw : StHw;
            default: target = StSw;
          endcase
        end
      end
      default: target = StSw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!en_q) begin
      state_d = StIdle;
    end else if (state_q == StIdle || frame_end) begin
      // Leaving IDLE is not frame aligned; owner swaps otherwise wait for frame_end
      state_d = target;
    end
  end

  assign shadow_load = en_q && (state_d != StIdle) && ((state_q == StIdle) || frame_end);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      frm_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      if (!en_q || (state_d != state_q)) begin
        frm_q <= '0;
      end else if (frame_end && !hold_done) begin
        frm_q <= frm_q + 1'b1;
      end
      if (shadow_load) begin
        shadow_q <= (state_d == StHw) ? bus.hw_bcd : swdata_q;
      end
    end
  end

  // Display output
  logic [3:0] cur_nib;
  logic [7:0] glyph;
  logic       show;
  logic [7:0] seg_d;
  logic [5:0] dig_d;
  logic [7:0] seg_q;
  logic [5:0] dig_q;
  logic       hw_gnt_q;

  always_comb begin
    cur_nib = 4'h0;
    case (idx_q)
      3'd0:    cur_nib = shadow_q[3:0];
      3'd1:    cur_nib = shadow_q[7:4];
      3'd2:    cur_nib = shadow_q[11:8];
      3'd3:    cur_nib = shadow_q[15:12];
      3'd4:    cur_nib = shadow_q[19:16];
      3'd5:    cur_nib = shadow_q[23:20];
      default: cur_nib = 4'h0;
    endcase
  end

  seg7_decoder u_decoder (
    .nibble (cur_nib),
    .glyph  (glyph)
  );

  // en_q gating blanks the pins on the cycle after EN is cleared
  assign show = en_q && (state_q != StIdle) && digmask_q[idx_q];

  always_comb begin
    seg_d = GLYPH_BLANK;
    dig_d = 6'h3F;
    if (show) begin
      seg_d        = glyph;
      dig_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      seg_q    <= GLYPH_BLANK;
      dig_q    <= 6'h3F;
      hw_gnt_q <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      hw_gnt_q <= (state_q == StHw);
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign bus.hw_gnt = hw_gnt_q;

  // APB read path
  logic [31:0] prdata;

  always_comb begin
    prdata = '0;
    case (reg_sel)
      REG_CTRL:    prdata[2:0]  = {mode_q, en_q};
      REG_SWDATA:  prdata[23:0] = swdata_q;
      REG_STATUS:  prdata[6:0]  = {state_q, idx_q, hw_gnt_q, (state_q == StHw)};
      REG_DIGMASK: prdata[5:0]  = digmask_q;
      default: ;
    endcase
  end

  assign bus.PRDATA  = prdata;
  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = 1'b0;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.PADDR[11:5], bus.PWDATA[31:24]};

endmodule
